// File: rtl/sram_req_pkg.sv
// Shared types and constants for the SRAM request controller and its response buffer.
package sram_req_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int unsigned RSP_DEPTH = 2;
  localparam logic [63:0] INIT_WORD = 64'h0;

endpackage

// File: rtl/sram_rsp_fifo.sv
// Two-entry synchronous response buffer; head entry is presented on o_data and
// stays stable until popped.
module sram_rsp_fifo
  import sram_req_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [1:0]            o_occ
);

  logic [DATA_WIDTH-1:0] mem_q [RSP_DEPTH];
  logic                  rd_ptr_q, rd_ptr_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic [1:0]            occ_q, occ_d;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q + {1'b0, i_push} - {1'b0, i_pop};
    if (i_push) begin
      wr_ptr_d = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (i_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < RSP_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (i_push) begin
        mem_q[wr_ptr_q] <= i_push_data;
      end
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign o_valid = (occ_q != 2'd0);
  assign o_data  = mem_q[rd_ptr_q];
  assign o_occ   = occ_q;

endmodule

// File: rtl/sram_req_ctrl.sv
// Request-side controller for the single-port SRAM. Define SRAM_REQ_CTRL_INIT_EN
// to zero-fill the whole memory after reset before accepting requests.
module sram_req_ctrl
  import sram_req_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_write,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_data,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_data,
  output logic [ADDR_WIDTH-1:0] o_sram_addr,
  output logic                  o_sram_write,
  output logic [DATA_WIDTH-1:0] o_sram_data,
  input  logic [DATA_WIDTH-1:0] i_sram_data,
  output logic                  o_busy
);

  if (DEPTH > (1 << ADDR_WIDTH)) begin : g_depth_check
    $error("DEPTH does not fit in ADDR_WIDTH");
  end

  state_e     state_q, state_d;
  logic       rd_pend_q, rd_pend_d;
  logic [1:0] occ_s;
  logic [2:0] credit_s;
  logic       pop_s, fire_s;

`ifdef SRAM_REQ_CTRL_INIT_EN
  localparam state_e                RESET_STATE = INIT;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(DEPTH - 1);
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
`else
  localparam state_e RESET_STATE = RUN;
`endif

  // The in-flight read counts against buffer space so a push never finds it full.
  assign pop_s       = o_rsp_valid & i_rsp_ready;
  assign credit_s    = {1'b0, occ_s} + {2'b00, rd_pend_q} - {2'b00, pop_s};
  assign o_req_ready = (state_q == RUN) && (credit_s < 3'd2);
  assign fire_s      = i_req_valid & o_req_ready;

  always_comb begin
    state_d      = state_q;
    rd_pend_d    = 1'b0;
    o_sram_addr  = i_req_addr;
    o_sram_data  = i_req_data;
    o_sram_write = fire_s & i_req_write;
`ifdef SRAM_REQ_CTRL_INIT_EN
    init_cnt_d   = init_cnt_q;
`endif
    case (state_q)
      INIT: begin
`ifdef SRAM_REQ_CTRL_INIT_EN
        o_sram_addr  = init_cnt_q;
        o_sram_data  = DATA_WIDTH'(INIT_WORD);
        o_sram_write = 1'b1;
        if (init_cnt_q == LAST_ADDR) begin
          state_d = RUN;
        end else begin
          init_cnt_d = init_cnt_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        end
`else
        state_d = RUN;
`endif
      end
      RUN: begin
        rd_pend_d = fire_s & ~i_req_write;
      end
      default: begin
        state_d = RESET_STATE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= RESET_STATE;
      rd_pend_q <= 1'b0;
`ifdef SRAM_REQ_CTRL_INIT_EN
      init_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      rd_pend_q <= rd_pend_d;
`ifdef SRAM_REQ_CTRL_INIT_EN
      init_cnt_q <= init_cnt_d;
`endif
    end
  end

`ifdef SRAM_REQ_CTRL_INIT_EN
  assign o_busy = (state_q == INIT);
`else
  assign o_busy = 1'b0;
`endif

  // The SRAM read register is overwritten every non-write cycle, so capture only when flagged.
  sram_rsp_fifo #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_rsp_fifo (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_push     (rd_pend_q),
    .i_push_data(i_sram_data),
    .i_pop      (pop_s),
    .o_valid    (o_rsp_valid),
    .o_data     (o_rsp_data),
    .o_occ      (occ_s)
  );

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Directed self-checking bench for sram_req_ctrl with a behavioural single-port SRAM.
module tb_sram_req_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_write = 1'b0;
  logic [5:0] req_addr = 6'd0;
  logic [7:0] req_data = 8'h00;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic [5:0] sram_addr;
  logic       sram_write;
  logic [7:0] sram_wdata;
  logic [7:0] sram_rdata = 8'h00;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] sram_mem [64];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sram_write) sram_mem[sram_addr] <= sram_wdata;
    else            sram_rdata <= sram_mem[sram_addr];
  end

  sram_req_ctrl #(.ADDR_WIDTH(6), .DATA_WIDTH(8), .DEPTH(64)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_write(req_write),
    .i_req_addr(req_addr), .i_req_data(req_data),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data),
    .o_sram_addr(sram_addr), .o_sram_write(sram_write), .o_sram_data(sram_wdata),
    .i_sram_data(sram_rdata), .o_busy(busy)
  );

  task automatic drive(input logic v, input logic w, input logic [5:0] a, input logic [7:0] d);
    @(negedge clk);
    req_valid = v; req_write = w; req_addr = a; req_data = d;
    #1;
  endtask

  task automatic finish_init();
`ifdef SRAM_REQ_CTRL_INIT_EN
    int bad;
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      #1;
      if (busy !== 1'b1 || sram_write !== 1'b1 || sram_addr !== 6'(i) ||
          sram_wdata !== 8'h00 || req_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL init_fill: %0d bad cycles, required 0", bad);
    end
`endif
    #1;
    checks++;
    if (busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL run_entry: busy=%b ready=%b, required busy=0 ready=1", busy, req_ready);
    end
  endtask

  task automatic test_reset();
    logic exp_ready, exp_write;
`ifdef SRAM_REQ_CTRL_INIT_EN
    exp_ready = 1'b0; exp_write = 1'b1;
`else
    exp_ready = 1'b1; exp_write = 1'b0;
`endif
    rst_n = 1'b0; rsp_ready = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_rsp: valid=%b data=%h, required 0/00", rsp_valid, rsp_data);
    end
    checks++;
    if (req_ready !== exp_ready || sram_write !== exp_write || busy !== exp_write) begin
      errors++;
      $display("FAIL reset_ctrl: ready=%b write=%b busy=%b, required %b/%b/%b",
               req_ready, sram_write, busy, exp_ready, exp_write, exp_write);
    end
    @(negedge clk);
    rst_n = 1'b1;
    finish_init();
  endtask

  task automatic test_write_read();
    rsp_ready = 1'b1;
    drive(1'b1, 1'b1, 6'd3, 8'h5A);
    checks++;
    if (req_ready !== 1'b1 || sram_write !== 1'b1 || sram_addr !== 6'd3 || sram_wdata !== 8'h5A) begin
      errors++;
      $display("FAIL wr_issue: ready=%b we=%b addr=%0d data=%h, required 1/1/3/5a",
               req_ready, sram_write, sram_addr, sram_wdata);
    end
    drive(1'b1, 1'b0, 6'd3, 8'hFF);
    checks++;
    if (req_ready !== 1'b1 || sram_write !== 1'b0) begin
      errors++;
      $display("FAIL rd_issue: ready=%b we=%b, required 1/0", req_ready, sram_write);
    end
    drive(1'b0, 1'b0, 6'd0, 8'h00);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_latency: valid=%b one cycle after read, required 0", rsp_valid);
    end
    drive(1'b0, 1'b0, 6'd0, 8'h00);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 8'h5A) begin
      errors++;
      $display("FAIL raw_data: valid=%b data=%h, required 1/5a", rsp_valid, rsp_data);
    end
    drive(1'b0, 1'b0, 6'd0, 8'h00);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_pop: valid=%b after pop, required 0", rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 6'(i + 1), vals[i]);
      checks++;
      if (req_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_wr_ready: cycle %0d ready=%b, required 1", i, req_ready);
      end
    end
    for (int i = 0; i < 6; i++) begin
      if (i < 3) drive(1'b1, 1'b0, 6'(i + 1), 8'h00);
      else       drive(1'b0, 1'b0, 6'd0, 8'h00);
      if (i < 3) begin
        checks++;
        if (req_ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b_rd_ready: cycle %0d ready=%b, required 1", i, req_ready);
        end
      end
      checks++;
      if (i >= 2 && i <= 4) begin
        if (rsp_valid !== 1'b1 || rsp_data !== vals[i-2]) begin
          errors++;
          $display("FAIL b2b_rsp: cycle %0d valid=%b data=%h, required 1/%h", i, rsp_valid, rsp_data, vals[i-2]);
        end
      end else if (rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL b2b_idle: cycle %0d valid=%b, required 0", i, rsp_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    drive(1'b1, 1'b0, 6'd1, 8'h00);
    drive(1'b1, 1'b0, 6'd2, 8'h00);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_second_accept: ready=%b, required 1", req_ready);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 6'd0, 8'h00);
      checks++;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_data !== 8'h11) begin
        errors++;
        $display("FAIL bp_hold: cycle %0d ready=%b valid=%b data=%h, required 0/1/11",
                 i, req_ready, rsp_valid, rsp_data);
      end
    end
    @(negedge clk); rsp_ready = 1'b1; #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b1 || rsp_data !== 8'h11) begin
      errors++;
      $display("FAIL bp_release1: ready=%b valid=%b data=%h, required 1/1/11", req_ready, rsp_valid, rsp_data);
    end
    drive(1'b0, 1'b0, 6'd0, 8'h00);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 8'h22) begin
      errors++;
      $display("FAIL bp_release2: valid=%b data=%h, required 1/22", rsp_valid, rsp_data);
    end
    drive(1'b0, 1'b0, 6'd0, 8'h00);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_drain: valid=%b ready=%b, required 0/1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset_midop();
    int bad;
    bad = 0;
    rsp_ready = 1'b0;
    drive(1'b1, 1'b0, 6'd1, 8'h00);
    drive(1'b1, 1'b0, 6'd2, 8'h00);
    drive(1'b0, 1'b0, 6'd0, 8'h00);
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL midop_pre: valid=%b, required 1", rsp_valid);
    end
    rst_n = 1'b0; #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== 8'h00) begin
      errors++;
      $display("FAIL midop_async: valid=%b data=%h, required 0/00", rsp_valid, rsp_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    finish_init();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 6'd0, 8'h00);
      if (rsp_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL midop_stale: %0d cycles with valid=1, required 0", bad);
    end
  endtask

  task automatic test_write_credit();
    rsp_ready = 1'b0;
    drive(1'b1, 1'b0, 6'd1, 8'h00);
    drive(1'b1, 1'b0, 6'd2, 8'h00);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 6'd5, 8'h77);
      checks++;
      if (req_ready !== 1'b0 || sram_write !== 1'b0) begin
        errors++;
        $display("FAIL wc_blocked: cycle %0d ready=%b we=%b, required 0/0", i, req_ready, sram_write);
      end
    end
    @(negedge clk); rsp_ready = 1'b1; #1;
    checks++;
    if (req_ready !== 1'b1 || sram_write !== 1'b1 || rsp_data !== 8'h11) begin
      errors++;
      $display("FAIL wc_accept: ready=%b we=%b data=%h, required 1/1/11", req_ready, sram_write, rsp_data);
    end
    drive(1'b1, 1'b1, 6'd6, 8'h66);
    checks++;
    if (req_ready !== 1'b1 || sram_write !== 1'b1 || rsp_data !== 8'h22) begin
      errors++;
      $display("FAIL wc_accept2: ready=%b we=%b data=%h, required 1/1/22", req_ready, sram_write, rsp_data);
    end
    drive(1'b1, 1'b0, 6'd5, 8'h00);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL wc_no_wr_rsp: valid=%b, required 0", rsp_valid);
    end
    drive(1'b0, 1'b0, 6'd0, 8'h00);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL wc_no_wr_rsp2: valid=%b, required 0", rsp_valid);
    end
    drive(1'b0, 1'b0, 6'd0, 8'h00);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 8'h77) begin
      errors++;
      $display("FAIL wc_readback: valid=%b data=%h, required 1/77", rsp_valid, rsp_data);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_backpressure();
    test_reset_midop();
    test_write_credit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
